rts_pulse_gen: RTL and testbench
================================

# rts_pulse_gen

Host-side counterpart of the Propeller RTS reset-window logic: generates a clean, timed, active-low `rts` pulse toward a Propeller target, then waits out the target's boot-listen hold-off before reporting ready. Sits between a loader/host controller (or a synchronized host RTS line) and the `rts` input of a downstream P1V or real Propeller, all in the `clock_160` domain.

## Interface
Parameters:
- `PULSE_CYCLES`, 1_600_000: `rts` low time in clocks (10 ms at 160 MHz); ≥1.
- `HOLDOFF_CYCLES`, 8_000_000: post-release wait in clocks (50 ms, matches the target's reset window); ≥1.
- `CNT_W`, 25: counter width. Both counts must be < 2^CNT_W; elaboration error otherwise.

Ports:
- `clock_160`  in  1  system clock.
- `inp_resn`  in  1  asynchronous active-low reset.
- `req`  in  1  synchronous start request, level-sampled each clock.
- `host_rts`  in  1  asynchronous host RTS line; a falling edge counts as a request.
- `rts`  out  1  to target, active-low reset pulse; idle high.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-clock pulse on the last HOLDOFF cycle.
- `ready`  out  1  high after a completed sequence; cleared when a new one starts.

## Operation
- Reset values: `rts`=1, `busy`=0, `done`=0, `ready`=0, state IDLE, counter 0, synchronizer flops 1.
- Start condition `start` = `req` OR synchronized falling edge of `host_rts`.
- States:
  - IDLE: on `start`, load counter with PULSE_CYCLES-1, clear `ready`, go to ASSERT.
  - ASSERT: `rts`=0. Counter decrements each clock. At 0, load HOLDOFF_CYCLES-1 and go to HOLDOFF.
  - HOLDOFF: `rts`=1. Counter decrements. At 0, pulse `done`, set `ready`, go to IDLE.
- `start` in ASSERT/HOLDOFF is ignored unless RTS_RETRIGGER_EN is defined.
- `req` held high continuously re-arms: after IDLE is reached, the next clock starts a new sequence.
- `inp_resn` low at any point aborts immediately: `rts` returns high asynchronously and all outputs take reset values. No partial pulse is resumed.
- Counter arithmetic is unsigned CNT_W-bit; no wrap is reachable because terminal detect is `==0`.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `req` high at edge N → `rts`=0, `busy`=1, `ready`=0 from edge N+1.
- `rts` stays low exactly PULSE_CYCLES clocks, then stays high for HOLDOFF_CYCLES clocks before IDLE.
- `done` is high in the clock where state leaves HOLDOFF; `ready` rises in the same edge; `busy` falls one clock later.
- `host_rts` path latency: 2-flop sync plus edge register. A falling edge at the pin produces `rts`=0 3–4 clocks later.
- Total sequence: 1 + PULSE_CYCLES + HOLDOFF_CYCLES clocks from request edge to return to IDLE.

## Configuration
- `RTS_RETRIGGER_EN` defined: `start` in ASSERT reloads PULSE_CYCLES-1, extending the pulse. `start` in HOLDOFF returns to ASSERT with PULSE_CYCLES-1 loaded. `done` is not pulsed for the aborted sequence.
- Not defined: `start` in ASSERT or HOLDOFF has no effect.

## Structure
- Shared package `p1v_rst_pkg`:
  - state enum `rts_state_t` (IDLE, ASSERT, HOLDOFF);
  - default localparams `RTS_PULSE_DEF`, `RTS_HOLDOFF_DEF`, `RTS_CNT_W`.
- Sub-module `rts_sync`: 2-flop synchronizer on `host_rts` with registered falling-edge pulse output. Its flops reset to 1 so that reset release does not produce a false edge.
- The FSM and counter live in `rts_pulse_gen`.

## Test plan
Bench parameters: PULSE_CYCLES=4, HOLDOFF_CYCLES=6.
- Single-cycle `req` at edge 10 → `rts` low at edges 11–14, high from 15. `done` pulses once at edge 20, `ready`=1 from 21, `busy`=0 at 22.
- `host_rts` driven 1→0 mid-cycle → `rts` falls within 4 clocks and the pulse is 4 clocks wide. A 0→1 transition produces no sequence.
- Without macro, `req` pulses at pulse clock 2 and holdoff clock 3 → timing identical to the single-request case.
- With `RTS_RETRIGGER_EN`, `req` at pulse clock 2 → `rts` low 6 clocks total. `req` in HOLDOFF → a new 4-clock low pulse and only one `done`.
- `inp_resn` low during ASSERT → `rts`=1, `busy`=0, `ready`=0 without waiting for a clock. After release, the block stays IDLE until the next `req`.
- `req` held high → back-to-back sequences 11 clocks apart, `done` every 11 clocks, `ready` high for exactly one clock each time.

Source files
------------

// File: rtl/p1v_rst_pkg.sv
// Shared types and defaults for the host-side RTS reset-pulse generator.
// RTS_RETRIGGER_EN (optional) lets a new start extend or restart a running sequence.
package p1v_rst_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } rts_state_t;

    // 10 ms pulse and 50 ms hold-off at 160 MHz; both fit a 25-bit counter.
    localparam int RTS_PULSE_DEF   = 1_600_000;
    localparam int RTS_HOLDOFF_DEF = 8_000_000;
    localparam int RTS_CNT_W       = 25;

    // True when a cycle count is representable as an unsigned value of the given width.
    function automatic bit rts_fits(input int cycles, input int width);
        if (width >= 31) begin
            return 1'b1;
        end
        return cycles < (1 << width);
    endfunction

endpackage

// File: rtl/rts_sync.sv
// Two-flop synchronizer for the asynchronous host RTS line with a registered
// one-clock pulse on each synchronized falling edge.
module rts_sync (
    input  logic clock_160,
    input  logic inp_resn,
    input  logic i_host_rts,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_fall;

    // Flops reset to the idle-high level so releasing reset never looks like a falling edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_host_rts;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_fall <= r_prev & ~r_sync;
        end
    end

    assign o_fall = r_fall;

endmodule

// File: rtl/rts_pulse_gen.sv
// Timed active-low RTS pulse toward a Propeller target followed by a boot-listen hold-off.
// Build option: RTS_RETRIGGER_EN makes a start during ASSERT/HOLDOFF restart the pulse.
module rts_pulse_gen
    import p1v_rst_pkg::*;
#(
    parameter int PULSE_CYCLES   = RTS_PULSE_DEF,
    parameter int HOLDOFF_CYCLES = RTS_HOLDOFF_DEF,
    parameter int CNT_W          = RTS_CNT_W
) (
    input  logic clock_160,
    input  logic inp_resn,
    input  logic req,
    input  logic host_rts,
    output logic rts,
    output logic busy,
    output logic done,
    output logic ready
);

    if (PULSE_CYCLES < 1 || HOLDOFF_CYCLES < 1) begin : g_chk_min
        $error("rts_pulse_gen: PULSE_CYCLES and HOLDOFF_CYCLES must be at least 1");
    end
    if (!rts_fits(PULSE_CYCLES, CNT_W) || !rts_fits(HOLDOFF_CYCLES, CNT_W)) begin : g_chk_width
        $error("rts_pulse_gen: cycle counts must be below 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    rts_state_t       r_state;
    rts_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_req;
    logic             w_fall;
    logic             w_start;
    logic             w_cnt_zero;
    logic             w_seq_end;

    logic             r_rts;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;
    logic             w_rts_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_ready_nxt;

    rts_sync u_sync (
        .clock_160  (clock_160),
        .inp_resn   (inp_resn),
        .i_host_rts (host_rts),
        .o_fall     (w_fall)
    );

    // Both start sources are registered, so the FSM acts one clock after req is sampled.
    assign w_start    = r_req | w_fall;
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rts   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_req   <= req;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rts   <= w_rts_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_seq_end   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = ASSERT;
                    w_cnt_nxt   = PULSE_LOAD;
                end
            end
            ASSERT: begin
                if (w_cnt_zero) begin
                    w_state_nxt = HOLDOFF;
                    w_cnt_nxt   = HOLDOFF_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
`ifdef RTS_RETRIGGER_EN
                if (w_start) begin
                    w_state_nxt = ASSERT;
                    w_cnt_nxt   = PULSE_LOAD;
                end
`endif
            end
            HOLDOFF: begin
                if (w_cnt_zero) begin
                    w_state_nxt = IDLE;
                    w_seq_end   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
`ifdef RTS_RETRIGGER_EN
                // On the final hold-off clock the window has fully elapsed and done
                // has already been shown; the restart then simply follows it.
                if (w_start) begin
                    w_state_nxt = ASSERT;
                    w_cnt_nxt   = PULSE_LOAD;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state; busy also covers the current
    // state so it drops one clock after ready rises.
    always_comb begin
        w_rts_nxt   = (w_state_nxt != ASSERT);
        w_busy_nxt  = (w_state_nxt != IDLE) || (r_state != IDLE);
        w_done_nxt  = (w_state_nxt == HOLDOFF) && (w_cnt_nxt == '0);
        w_ready_nxt = r_ready;
        if (w_seq_end && (w_state_nxt == IDLE)) begin
            w_ready_nxt = 1'b1;
        end
        if (w_state_nxt == ASSERT) begin
            w_ready_nxt = 1'b0;
        end
    end

    assign rts   = r_rts;
    assign busy  = r_busy;
    assign done  = r_done;
    assign ready = r_ready;

endmodule

// File: tb/tb_rts_pulse_gen.sv
// Self-checking bench for rts_pulse_gen with PULSE_CYCLES=4, HOLDOFF_CYCLES=6.
// Expected output words are queued when stimulus is driven and compared per cycle.
module tb_rts_pulse_gen;

    localparam int P = 4;
    localparam int H = 6;

    logic clock_160 = 1'b0;
    logic inp_resn  = 1'b0;
    logic req       = 1'b0;
    logic host_rts  = 1'b1;
    logic rts;
    logic busy;
    logic done;
    logic ready;

    rts_pulse_gen #(
        .PULSE_CYCLES   (P),
        .HOLDOFF_CYCLES (H),
        .CNT_W          (8)
    ) dut (
        .clock_160 (clock_160),
        .inp_resn  (inp_resn),
        .req       (req),
        .host_rts  (host_rts),
        .rts       (rts),
        .busy      (busy),
        .done      (done),
        .ready     (ready)
    );

    always #5 clock_160 = ~clock_160;

    // Edge counter: value seen at a falling edge is the number of the last rising edge.
    int cyc = 0;
    always @(posedge clock_160) cyc++;

    typedef struct {
        int         at;
        logic [3:0] exp;   // {rts, busy, done, ready}
        string      tag;
    } sb_item_t;

    sb_item_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs d edges after the edge where a request is sampled.
    function automatic logic [3:0] seq_exp(input int d, input logic rdy0);
        logic r;
        logic b;
        logic dn;
        logic rd;
        r  = !(d >= 1 && d <= P);
        b  = (d >= 1 && d <= P + H + 1);
        dn = (d == P + H);
        rd = (d == 0) ? rdy0 : (d >= P + H + 1);
        return {r, b, dn, rd};
    endfunction

    task automatic push(input int at, input logic [3:0] e, input string tag);
        sb.push_back('{at, e, tag});
    endtask

    task automatic push_seq(input int n, input logic rdy0, input int d_lo, input int d_hi,
                            input string tag);
        for (int d = d_lo; d <= d_hi; d++) begin
            push(n + d, seq_exp(d, rdy0), $sformatf("%s_d%0d", tag, d));
        end
    endtask

    task automatic check_front();
        sb_item_t   it;
        logic [3:0] obs;
        it  = sb.pop_front();
        obs = {rts, busy, done, ready};
        n_checks++;
        assert (obs === it.exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed rts/busy/done/ready=%b expected=%b",
                   it.tag, it.at, obs, it.exp);
        end
    endtask

    task automatic tick();
        @(negedge clock_160);
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            check_front();
        end
    endtask

    task automatic run_to(input int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 1000) begin
            tick();
            guard++;
        end
    endtask

    initial begin
        int n;
        int c;

        // Reset state while reset is held.
        repeat (3) @(negedge clock_160);
        push(cyc, 4'b1000, "reset_hold");
        check_front();
        inp_resn = 1'b1;
        c = cyc;
        for (int i = 1; i <= 3; i++) push(c + i, 4'b1000, "idle_after_reset");
        run_to(c + 3);

        // Single-cycle request.
        n = cyc + 1;
        req = 1'b1;
        push_seq(n, 1'b0, 0, 12, "single");
        tick();
        req = 1'b0;
        run_to(n + 12);

        // Falling edge on host_rts driven mid-cycle.
        c = cyc;
        #2 host_rts = 1'b0;
        push(c + 1, 4'b1001, "host_wait1");
        push(c + 2, 4'b1001, "host_wait2");
        push_seq(c + 3, 1'b1, 0, 12, "host_fall");
        run_to(c + 15);

        // Rising edge produces no sequence.
        c = cyc;
        #2 host_rts = 1'b1;
        for (int i = 1; i <= 6; i++) push(c + i, 4'b1001, "host_rise");
        run_to(c + 6);

`ifdef RTS_RETRIGGER_EN
        // Request at pulse clock 2 extends the low time to 6 clocks.
        n = cyc + 1;
        req = 1'b1;
        push_seq(n, 1'b1, 0, 2, "retrig_a1");
        push_seq(n + 2, 1'b1, 1, 12, "retrig_a2");
        tick();
        req = 1'b0;
        run_to(n + 1);
        req = 1'b1;
        run_to(n + 2);
        req = 1'b0;
        run_to(n + 14);

        // Request in hold-off starts a fresh pulse; only the new sequence shows done.
        n = cyc + 1;
        req = 1'b1;
        push_seq(n, 1'b1, 0, 7, "retrig_h1");
        push_seq(n + 7, 1'b1, 1, 12, "retrig_h2");
        tick();
        req = 1'b0;
        run_to(n + 6);
        req = 1'b1;
        run_to(n + 7);
        req = 1'b0;
        run_to(n + 19);
`else
        // Requests during ASSERT and HOLDOFF are ignored.
        n = cyc + 1;
        req = 1'b1;
        push_seq(n, 1'b1, 0, 12, "ignored");
        tick();
        req = 1'b0;
        run_to(n + 1);
        req = 1'b1;
        run_to(n + 2);
        req = 1'b0;
        run_to(n + 6);
        req = 1'b1;
        run_to(n + 7);
        req = 1'b0;
        run_to(n + 12);
`endif

        // Reset during ASSERT takes effect without a clock.
        n = cyc + 1;
        req = 1'b1;
        push_seq(n, 1'b1, 0, 2, "rst_pre");
        tick();
        req = 1'b0;
        run_to(n + 2);
        #1 inp_resn = 1'b0;
        #1 push(cyc, 4'b1000, "rst_async");
        check_front();
        tick();
        inp_resn = 1'b1;
        c = cyc;
        for (int i = 1; i <= 5; i++) push(c + i, 4'b1000, "idle_after_abort");
        run_to(c + 5);

`ifndef RTS_RETRIGGER_EN
        // Held request: back-to-back sequences 11 clocks apart.
        n = cyc + 1;
        req = 1'b1;
        push_seq(n, 1'b0, 0, 11, "held1");
        push_seq(n + 11, 1'b1, 1, 11, "held2");
        push_seq(n + 22, 1'b1, 1, 12, "held3");
        run_to(n + 25);
        req = 1'b0;
        run_to(n + 34);
`endif

        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
